// File: rtl/store_buffer.sv
// store_buffer: in-order store queue sitting between the store FU and the
// dcache. Up to two stores are accepted per cycle. Retirement commits them in
// order, and committed stores drain to the dcache one at a time over a
// req/ack handshake. Loads are checked against every buffered store at word
// granularity.
module store_buffer #(
  parameter int SQ_NUM = 16,
  parameter int PTR_W  = $clog2(SQ_NUM)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en1,
  input  logic             wr_en2,
  input  logic [31:0]      addr1,
  input  logic [31:0]      addr2,
  input  logic [31:0]      data1,
  input  logic [31:0]      data2,
  input  logic [2:0]       size1,
  input  logic [2:0]       size2,
  input  logic [1:0]       commit_num,
  input  logic             cache_wr_ack,
  output logic             wr_cache,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic [2:0]       wr_size,
  input  logic [31:0]      ld_addr,
  output logic             ld_conflict,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W = PTR_W + 1;
  // Full means fewer than two free slots, so a dual allocation always fits
  // whenever full is low.
  localparam logic [CNT_W-1:0] FULL_LIM = CNT_W'(SQ_NUM - 2);

  logic [31:0]       addr_q [SQ_NUM];
  logic [31:0]       data_q [SQ_NUM];
  logic [2:0]        size_q [SQ_NUM];
  logic [SQ_NUM-1:0] valid_q;
  logic [SQ_NUM-1:0] committed_q;

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  cmt_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;
  // Valid entries not yet committed. Kept as its own counter so that commit
  // clamping never has to interpret pointer distances, which are ambiguous
  // when the queue wraps.
  logic [CNT_W-1:0]  uncmt_q;

  logic              alloc_ok;
  logic              first_en;
  logic              second_en;
  logic [1:0]        n_alloc;
  logic [PTR_W-1:0]  tail_p1;
  logic [PTR_W-1:0]  cmt_p1;
  logic [31:0]       first_addr;
  logic [31:0]       first_data;
  logic [2:0]        first_size;
  logic [1:0]        commit_req;
  logic [1:0]        n_commit;
  logic              drain;
  logic              unused_ld_lo;

  assign unused_ld_lo = ^ld_addr[1:0];

  // Status flags and the allocation/commit/drain amounts for this cycle.
  always_comb begin
    full       = (count_q > FULL_LIM);
    empty      = (count_q == '0);
    count      = count_q;

    alloc_ok   = !full;
    first_en   = alloc_ok && (wr_en1 || wr_en2);
    second_en  = alloc_ok && wr_en1 && wr_en2;
    n_alloc    = {1'b0, first_en} + {1'b0, second_en};
    tail_p1    = tail_q + PTR_W'(1);
    cmt_p1     = cmt_q + PTR_W'(1);

    // A lone store2 still goes to tail; the pair case puts store2 after store1.
    first_addr = wr_en1 ? addr1 : addr2;
    first_data = wr_en1 ? data1 : data2;
    first_size = wr_en1 ? size1 : size2;

    // Commits are clamped to entries that were valid before this edge, so a
    // store allocated this cycle can only be committed from the next cycle on.
    commit_req = (commit_num > 2'd2) ? 2'd2 : commit_num;
    if (uncmt_q < CNT_W'(commit_req)) begin
      n_commit = uncmt_q[1:0];
    end else begin
      n_commit = commit_req;
    end
  end

  // Drain request straight from registered head state; payload zeroed when idle.
  always_comb begin
    wr_cache = valid_q[head_q] && committed_q[head_q];
    wr_addr  = '0;
    wr_data  = '0;
    wr_size  = '0;
    if (wr_cache) begin
      wr_addr = addr_q[head_q];
      wr_data = data_q[head_q];
      wr_size = size_q[head_q];
    end
    drain = wr_cache && cache_wr_ack;
  end

  // Conservative load check: any valid entry in the same word, committed or not.
  always_comb begin
    ld_conflict = 1'b0;
    for (int i = 0; i < SQ_NUM; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
        ld_conflict = 1'b1;
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (first_en) begin
        addr_q[tail_q] <= first_addr;
        data_q[tail_q] <= first_data;
        size_q[tail_q] <= first_size;
      end
      if (second_en) begin
        addr_q[tail_p1] <= addr2;
        data_q[tail_p1] <= data2;
        size_q[tail_p1] <= size2;
      end
    end
  end

  // Pointers, counters and per-entry valid/committed bits.
  // Drain, commit and allocate always touch disjoint slots: the drained head is
  // committed, commit targets are uncommitted, and allocation targets free slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      cmt_q       <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      uncmt_q     <= '0;
      valid_q     <= '0;
      committed_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(drain);
      cmt_q   <= cmt_q + PTR_W'(n_commit);
      tail_q  <= tail_q + PTR_W'(n_alloc);
      count_q <= count_q + CNT_W'(n_alloc) - CNT_W'(drain);
      uncmt_q <= uncmt_q + CNT_W'(n_alloc) - CNT_W'(n_commit);

      if (drain) begin
        valid_q[head_q]     <= 1'b0;
        committed_q[head_q] <= 1'b0;
      end
      if (n_commit != 2'd0) begin
        committed_q[cmt_q] <= 1'b1;
      end
      if (n_commit == 2'd2) begin
        committed_q[cmt_p1] <= 1'b1;
      end
      if (first_en) begin
        valid_q[tail_q] <= 1'b1;
      end
      if (second_en) begin
        valid_q[tail_p1] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer. Expected dcache writes are
// queued as stores are driven and checked in order as each handshake completes.
module tb_store_buffer;

  localparam int SQ_NUM = 16;
  localparam int PTR_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             wr_en1, wr_en2;
  logic [31:0]      addr1, addr2, data1, data2;
  logic [2:0]       size1, size2;
  logic [1:0]       commit_num;
  logic             cache_wr_ack;
  logic             wr_cache;
  logic [31:0]      wr_addr, wr_data;
  logic [2:0]       wr_size;
  logic [31:0]      ld_addr;
  logic             ld_conflict, empty, full;
  logic [PTR_W:0]   count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  s;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  store_buffer #(.SQ_NUM(SQ_NUM)) dut (
    .clock(clock), .reset(reset),
    .wr_en1(wr_en1), .wr_en2(wr_en2),
    .addr1(addr1), .addr2(addr2),
    .data1(data1), .data2(data2),
    .size1(size1), .size2(size2),
    .commit_num(commit_num), .cache_wr_ack(cache_wr_ack),
    .wr_cache(wr_cache), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
    .ld_addr(ld_addr), .ld_conflict(ld_conflict),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare any completed handshake against the oldest expected write.
  task automatic clk_step();
    wr_t e;
    @(negedge clock);
    if (!reset && wr_cache === 1'b1 && cache_wr_ack === 1'b1) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed addr=0x%0h expected no write", wr_addr);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_addr", wr_addr, e.a);
        chk("sb_data", wr_data, e.d);
        chk("sb_size", {29'b0, wr_size}, {29'b0, e.s});
      end
    end
    @(posedge clock);
    #1;
  endtask

  // Drive an allocation; the model records it only if the queue has room.
  task automatic set_alloc(input logic e1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic [2:0] s1, input logic e2, input logic [31:0] a2,
                           input logic [31:0] d2, input logic [2:0] s2);
    wr_en1 = e1; addr1 = a1; data1 = d1; size1 = s1;
    wr_en2 = e2; addr2 = a2; data2 = d2; size2 = s2;
    if (exp_q.size() < SQ_NUM - 1) begin
      if (e1) exp_q.push_back('{a1, d1, s1});
      if (e2) exp_q.push_back('{a2, d2, s2});
    end
  endtask

  task automatic clr_alloc();
    wr_en1 = 1'b0;
    wr_en2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    reset = 1'b1; wr_en1 = 0; wr_en2 = 0; addr1 = 0; addr2 = 0; data1 = 0; data2 = 0;
    size1 = 0; size2 = 0; commit_num = 0; cache_wr_ack = 0; ld_addr = 0;
    clk_step();
    clk_step();
    reset = 1'b0;

    // Reset state
    chk("rst_wr_cache", wr_cache, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_size", wr_size, 0);
    chk("rst_ld_conflict", ld_conflict, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);

    // Single store, commit, ack withheld three cycles
    set_alloc(1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 0, 0, 0);
    clk_step();
    clr_alloc();
    commit_num = 2'd1;
    chk("t1_count", count, 1);
    chk("t1_no_req_uncommitted", wr_cache, 0);
    clk_step();
    commit_num = 2'd0;
    for (int i = 0; i < 3; i++) begin
      chk("t1_hold_req", wr_cache, 1);
      chk("t1_hold_addr", wr_addr, 32'h100);
      chk("t1_hold_data", wr_data, 32'hDEADBEEF);
      chk("t1_hold_size", wr_size, 2);
      clk_step();
    end
    cache_wr_ack = 1'b1;
    clk_step();
    cache_wr_ack = 1'b0;
    chk("t1_empty", empty, 1);
    chk("t1_count0", count, 0);
    chk("t1_req_idle", wr_cache, 0);

    // Dual allocation, dual commit, back-to-back drain
    set_alloc(1, 32'h200, 32'h11, 3'd2, 1, 32'h204, 32'h22, 3'd2);
    clk_step();
    clr_alloc();
    chk("t2_count", count, 2);
    commit_num = 2'd2;
    clk_step();
    commit_num = 2'd0;
    cache_wr_ack = 1'b1;
    chk("t2_first_addr", wr_addr, 32'h200);
    clk_step();
    chk("t2_second_req", wr_cache, 1);
    chk("t2_second_addr", wr_addr, 32'h204);
    clk_step();
    cache_wr_ack = 1'b0;
    chk("t2_empty", empty, 1);

    // Fill to the full threshold; a write while full is dropped
    for (int i = 0; i < 7; i++) begin
      set_alloc(1, 32'h1000 + 8*i, 32'hA000 + i, 3'd2, 1, 32'h1004 + 8*i, 32'hB000 + i, 3'd1);
      clk_step();
    end
    clr_alloc();
    chk("t3_count14", count, 14);
    chk("t3_not_full14", full, 0);
    set_alloc(1, 32'h1038, 32'hC000, 3'd0, 0, 0, 0, 0);
    clk_step();
    clr_alloc();
    chk("t3_count15", count, 15);
    chk("t3_full15", full, 1);
    set_alloc(1, 32'h5000, 32'hBAD, 3'd2, 0, 0, 0, 0);
    clk_step();
    clr_alloc();
    chk("t3_count_hold", count, 15);
    ld_addr = 32'h5000;
    #1;
    chk("t3_dropped_not_visible", ld_conflict, 0);
    commit_num = 2'd1;
    clk_step();
    commit_num = 2'd0;
    chk("t3_head_req", wr_cache, 1);
    chk("t3_head_addr", wr_addr, 32'h1000);
    cache_wr_ack = 1'b1;
    clk_step();
    cache_wr_ack = 1'b0;
    chk("t3_count_after_ack", count, 14);
    chk("t3_full_cleared", full, 0);
    commit_num = 2'd2;
    cache_wr_ack = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) clk_step();
    commit_num = 2'd0;
    cache_wr_ack = 1'b0;
    chk("t3_drain_done", exp_q.size(), 0);
    chk("t3_empty", empty, 1);

    // Load conflict against an uncommitted entry
    set_alloc(1, 32'h300, 32'h33, 3'd2, 0, 0, 0, 0);
    clk_step();
    clr_alloc();
    ld_addr = 32'h302;
    #1;
    chk("t4_conflict_same_word", ld_conflict, 1);
    ld_addr = 32'h304;
    #1;
    chk("t4_no_conflict_next_word", ld_conflict, 0);
    chk("t4_no_req", wr_cache, 0);
    cache_wr_ack = 1'b1;
    clk_step();
    clk_step();
    cache_wr_ack = 1'b0;
    chk("t4_stray_ack_ignored", count, 1);
    chk("t4_still_no_req", wr_cache, 0);
    commit_num = 2'd1;
    clk_step();
    commit_num = 2'd0;
    ld_addr = 32'h300;
    #1;
    chk("t4_req_after_commit", wr_cache, 1);
    chk("t4_conflict_until_ack", ld_conflict, 1);
    cache_wr_ack = 1'b1;
    clk_step();
    cache_wr_ack = 1'b0;
    chk("t4_conflict_gone", ld_conflict, 0);
    chk("t4_empty", empty, 1);

    // Wrap: 40 stores in pairs, commits alternating 1/2, ack always high
    issued = 0;
    cache_wr_ack = 1'b1;
    for (int cyc = 0; cyc < 400 && !(issued >= 40 && exp_q.size() == 0); cyc++) begin
      chk("t5_count", count, exp_q.size());
      chk("t5_full", full, exp_q.size() >= SQ_NUM - 1);
      if (issued < 40 && exp_q.size() < SQ_NUM - 1) begin
        set_alloc(1, 32'h4000 + 4*issued, 32'h5A00_0000 + issued, 3'(issued % 3), 1,
                  32'h4004 + 4*issued, 32'h5A00_0001 + issued, 3'((issued + 1) % 3));
        issued += 2;
      end else begin
        clr_alloc();
      end
      commit_num = (cyc % 2 == 0) ? 2'd1 : 2'd2;
      clk_step();
    end
    clr_alloc();
    commit_num = 2'd0;
    cache_wr_ack = 1'b0;
    chk("t5_issued", issued, 40);
    chk("t5_all_drained", exp_q.size(), 0);
    chk("t5_empty", empty, 1);

    // Reset while a drain request is pending, with a same-cycle ack
    set_alloc(1, 32'h6000, 32'h61, 3'd2, 1, 32'h6004, 32'h62, 3'd2);
    clk_step();
    set_alloc(1, 32'h6008, 32'h63, 3'd2, 1, 32'h600C, 32'h64, 3'd2);
    clk_step();
    set_alloc(1, 32'h6010, 32'h65, 3'd2, 0, 0, 0, 0);
    clk_step();
    clr_alloc();
    commit_num = 2'd2;
    clk_step();
    commit_num = 2'd0;
    chk("t6_count5", count, 5);
    chk("t6_req", wr_cache, 1);
    reset = 1'b1;
    cache_wr_ack = 1'b1;
    clk_step();
    reset = 1'b0;
    cache_wr_ack = 1'b0;
    exp_q.delete();
    ld_addr = 32'h6000;
    #1;
    chk("t6_req_dropped", wr_cache, 0);
    chk("t6_count0", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ld_conflict", ld_conflict, 0);
    chk("t6_wr_addr", wr_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
